// File: rtl/spi_config_master_pkg.sv
// Shared definitions for the SPI configuration master: FSM encoding and
// the byte count of a full configuration load.
package spi_config_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOAD,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   localparam int CFG_FRAME_BYTES = 215;

endpackage

// File: rtl/spi_config_master_if.sv
// Frame control, byte-stream handshake and SPI pins of the configuration
// master, bundled so the controller and its client share one port list.
interface spi_config_master_if;

   localparam int DW = 8;

   logic          start;
   logic [DW-1:0] frame_len;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          busy;
   logic          done;
   logic          SCLK;
   logic          MOSI;
   logic          SS;
   logic          MISO;

   modport master (
      input  start, frame_len, tx_data, tx_valid, MISO,
      output tx_ready, rx_data, rx_valid, busy, done, SCLK, MOSI, SS
   );

   modport slave (
      output start, frame_len, tx_data, tx_valid, MISO,
      input  tx_ready, rx_data, rx_valid, busy, done, SCLK, MOSI, SS
   );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: divider, SCLK register, edge strobes and
// per-byte bit counter. Runs only while enabled; otherwise parks at zero.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic system_clock,
   input  logic reset,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall,
   output logic o_last
);

   localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

   logic [7:0] r_div;
   logic [2:0] r_bit;
   logic       r_sclk;
   logic       w_wrap;

   assign w_wrap = i_en && (r_div == DIV_TC);

   always_ff @(posedge system_clock) begin
      if (!reset) begin
         r_div  <= 8'd0;
         r_bit  <= 3'd0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_div  <= 8'd0;
         r_bit  <= 3'd0;
         r_sclk <= 1'b0;
      end else if (w_wrap) begin
         r_div  <= 8'd0;
         r_sclk <= ~r_sclk;
         if (r_sclk)
            r_bit <= r_bit + 3'd1;
      end else begin
         r_div <= r_div + 8'd1;
      end
   end

   // Strobes mark the system edge on which SCLK itself toggles.
   assign o_sclk = r_sclk;
   assign o_rise = w_wrap && !r_sclk;
   assign o_fall = w_wrap && r_sclk;
   assign o_last = o_fall && (r_bit == 3'd7);

endmodule

// File: rtl/spi_config_master.sv
// SPI configuration master: streams frame_len bytes MSB-first in mode 0,
// captures MISO per byte, and frames the transfer with SS setup/hold.
//
// state    | meaning
// IDLE     | SS high, waiting for start with nonzero frame_len
// SETUP    | SS low, SS_SETUP cycles before the first byte
// LOAD     | tx_ready high, waiting for the next source byte
// SHIFT    | eight SCLK periods shifting the loaded byte
// HOLD     | SS low, SS_HOLD cycles after the last falling edge
module spi_config_master
   import spi_config_master_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int SS_SETUP = 2,
   parameter int SS_HOLD  = 2
) (
   input logic                 system_clock,
   input logic                 reset,
   spi_config_master_if.master bus
);

   localparam logic [7:0] SETUP_TC = 8'(SS_SETUP - 1);
   localparam logic [7:0] HOLD_TC  = 8'(SS_HOLD - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_byte_cnt;
   logic [7:0] r_tmr;
   logic [6:0] r_tx_sh;
   logic [7:0] r_rx_sh;
   logic [7:0] r_rx_data;
   logic       r_mosi;
   logic       r_ss;
   logic       r_tx_ready;
   logic       r_rx_valid;
   logic       r_busy;
   logic       r_done_pend;
   logic       r_done;
   logic       w_start;
   logic       w_accept;
   logic       w_en;
   logic       w_sclk;
   logic       w_rise;
   logic       w_fall;
   logic       w_last;

   assign w_start  = (r_state == ST_IDLE) && bus.start && (bus.frame_len != 8'd0);
   assign w_accept = r_tx_ready && bus.tx_valid;
   assign w_en     = (r_state == ST_SHIFT);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .system_clock (system_clock),
      .reset        (reset),
      .i_en         (w_en),
      .o_sclk       (w_sclk),
      .o_rise       (w_rise),
      .o_fall       (w_fall),
      .o_last       (w_last)
   );

   always_ff @(posedge system_clock) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start) w_next = ST_SETUP;
         ST_SETUP: if (r_tmr == 8'd0) w_next = ST_LOAD;
         ST_LOAD:  if (w_accept) w_next = ST_SHIFT;
         ST_SHIFT: if (w_last) w_next = (r_byte_cnt == 8'd1) ? ST_HOLD : ST_LOAD;
         ST_HOLD:  if (r_tmr == 8'd0) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up
   // with the state they describe without a combinational output path.
   always_ff @(posedge system_clock) begin
      if (!reset) begin
         r_byte_cnt  <= 8'd0;
         r_tmr       <= 8'd0;
         r_tx_sh     <= 7'd0;
         r_rx_sh     <= 8'd0;
         r_rx_data   <= 8'd0;
         r_mosi      <= 1'b0;
         r_ss        <= 1'b1;
         r_tx_ready  <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_ss        <= (w_next == ST_IDLE);
         r_busy      <= (w_next != ST_IDLE);
         r_tx_ready  <= (w_next == ST_LOAD);
         r_rx_valid  <= 1'b0;
         r_done_pend <= (r_state == ST_HOLD) && (w_next == ST_IDLE);
         r_done      <= r_done_pend;

         if (w_start) begin
            r_byte_cnt <= bus.frame_len;
            r_tmr      <= SETUP_TC;
         end else if ((r_state == ST_SETUP || r_state == ST_HOLD) && r_tmr != 8'd0) begin
            r_tmr <= r_tmr - 8'd1;
         end

         if (w_accept) begin
            r_mosi  <= bus.tx_data[7];
            r_tx_sh <= bus.tx_data[6:0];
         end

         if (w_rise)
            r_rx_sh <= {r_rx_sh[6:0], bus.MISO};

         // MOSI moves only on falling edges; the final one leaves it held.
         if (w_fall && !w_last) begin
            r_mosi  <= r_tx_sh[6];
            r_tx_sh <= {r_tx_sh[5:0], 1'b0};
         end

         if (w_last) begin
            r_byte_cnt <= r_byte_cnt - 8'd1;
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
            if (r_byte_cnt == 8'd1)
               r_tmr <= HOLD_TC;
         end
      end
   end

   assign bus.SS       = r_ss;
   assign bus.SCLK     = w_sclk;
   assign bus.MOSI     = r_mosi;
   assign bus.tx_ready = r_tx_ready;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

// File: doc/spi_config_master.md
SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in system_clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter SS_SETUP, default 2, giving the system_clock cycles from SS falling to the first SCLK rising edge.
REQ-003 The block SHALL have parameter SS_HOLD, default 2, giving the system_clock cycles from the last SCLK falling edge to SS rising.
REQ-004 The block SHALL have port system_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a frame; sampled only in IDLE.
REQ-007 The block SHALL have port frame_len, input, 8 bits: the number of bytes in the frame, latched when start is accepted (215 for a full configuration load).
REQ-008 The block SHALL have ports tx_data (input, 8 bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit): the byte source handshake.
REQ-009 The block SHALL have ports rx_data (output, 8 bits) and rx_valid (output, 1 bit): each byte captured from MISO.
REQ-010 The block SHALL have ports busy (output, 1 bit) and done (output, 1 bit): frame status.
REQ-011 The block SHALL have ports SCLK (output, 1 bit), MOSI (output, 1 bit), SS (output, 1 bit, active-low) and MISO (input, 1 bit).

Function
REQ-012 The FSM SHALL have states IDLE, SETUP, LOAD, SHIFT and HOLD.
REQ-013 In IDLE, start=1 with frame_len!=0 SHALL latch frame_len, drive SS low and enter SETUP on the next cycle; start with frame_len=0 SHALL be ignored.
REQ-014 SETUP SHALL last SS_SETUP cycles and then enter LOAD.
REQ-015 In LOAD, tx_ready SHALL be 1; a tx_valid&&tx_ready transfer SHALL load tx_data into the shift register and enter SHIFT on the next cycle.
REQ-016 If tx_valid is 0 in LOAD, the block SHALL stall with SS low, SCLK low and MOSI held, with no time limit.
REQ-017 The interface SHALL use SPI mode 0: SCLK idles low, MOSI is stable before each rising edge, and MISO is sampled on each rising edge.
REQ-018 Data SHALL be shifted MSB first, and bytes SHALL be sent in the order accepted.
REQ-019 Each bit SHALL take 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles; one byte SHALL take 16*CLK_DIV cycles in SHIFT.
REQ-020 MOSI SHALL present bit 7 of the loaded byte on the cycle SHIFT is entered, and SHALL change only on SCLK falling edges.
REQ-021 After the eighth falling edge, rx_data SHALL hold the 8 sampled bits (first sample in bit 7) and rx_valid SHALL pulse high for exactly one cycle.
REQ-022 After each byte, a byte counter SHALL decrement; if it is nonzero the FSM SHALL return to LOAD, and if it is zero the FSM SHALL enter HOLD.
REQ-023 There SHALL be no SCLK edge between bytes while in LOAD; an accept immediately after a byte SHALL add exactly one cycle of gap.
REQ-024 HOLD SHALL last SS_HOLD cycles; SS SHALL then go high, done SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start asserted while busy SHALL be ignored, and frame_len changes while busy SHALL have no effect.
REQ-027 tx_ready SHALL be 0 in every state except LOAD, so tx_data is never consumed outside LOAD.
REQ-028 The SCLK divider counter SHALL wrap from CLK_DIV-1 to 0 and toggle SCLK on the wrap; with CLK_DIV=1, SCLK SHALL toggle every cycle.

Reset
REQ-029 When reset=0 at a rising edge, the block SHALL enter IDLE with SS=1, SCLK=0, MOSI=0, tx_ready=0, rx_valid=0, done=0, busy=0, rx_data=0 and all counters at 0.
REQ-030 A reset mid-frame SHALL abort the frame with no done pulse and no rx_valid pulse; SS SHALL be high and SCLK low from the cycle after the reset edge.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the constant CFG_FRAME_BYTES=215; the interface widths stay local to the block.
REQ-032 The SCLK generator (divider counter, edge strobes, bit counter) SHALL be one sub-module named spi_sclk_gen; the FSM and shift registers SHALL stay in spi_config_master.
REQ-033 All outputs SHALL be registered, with no combinational path from MISO or tx_valid to any output.

Verification
REQ-034 Test 1: CLK_DIV=4, frame_len=1, tx_data=0xA5 valid, MISO looped to MOSI -> MOSI bits 1,0,1,0,0,1,0,1; 8 SCLK pulses of 8 cycles each; rx_data=0xA5 with one rx_valid pulse; done one cycle after SS rises.
REQ-035 Test 2: frame_len=3 with bytes 0x01,0x80,0xFF and tx_valid deasserted for 20 cycles before byte 2 -> SCLK low and SS low throughout the stall; 24 SCLK pulses total; bytes received in order.
REQ-036 Test 3: reset=0 on the 5th SCLK rising edge of byte 1 -> SS=1 and SCLK=0 the next cycle; busy=0; no rx_valid or done pulse; a new start then runs a clean frame.
REQ-037 Test 4: start with frame_len=0, and start pulses while busy -> no SS activity and no change in the byte count of the running frame.
REQ-038 Test 5: frame_len=215 (CFG_FRAME_BYTES) with random data and CLK_DIV=1 -> exactly 1720 SCLK rising edges, MOSI stream equals the source bytes MSB-first, and one done pulse.
REQ-039 Test 6: MISO driven with 0x3C pattern while sending 0x00 -> rx_data=0x3C, confirming sampling on the rising edge.
